vram_write_buffer: RTL

//   Write-side companion to the VGA scan-out path: accepts 16-bit screen-memory writes (Hack
//   CPU / loader) and commits them to the VRAM write port outside the line-fetch window.

---
 rtl/vga_pkg.sv | 17 +
 rtl/vram_wr_fifo.sv | 51 +++++
 rtl/vram_write_buffer.sv | 84 ++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA/VRAM constants and the buffered write payload, common to the timing
// generator, the VRAM and the write buffer.
package vga_pkg;

  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned FETCH_END   = 720;
  localparam int unsigned H_TOTAL     = 800;
  localparam int unsigned V_TOTAL     = 525;
  localparam int unsigned VRAM_ADDR_W = 14;
  localparam int unsigned VRAM_DATA_W = 16;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } vram_wr_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Write-buffer storage: circular FIFO with occupancy count and a tail data-overwrite
// port used to merge repeated writes to the newest entry.
module vram_wr_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        ovw,
  input  vram_wr_t                    din,
  input  logic [VRAM_DATA_W-1:0]      ovw_data,
  output vram_wr_t                    head,
  output logic [VRAM_ADDR_W-1:0]      tail_addr,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  vram_wr_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] tail_ptr;

  assign tail_ptr  = PTR_W'(wr_ptr - PTR_W'(1));
  assign head      = mem[rd_ptr];
  assign tail_addr = mem[tail_ptr].addr;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
    if (ovw)  mem[tail_ptr].data <= ovw_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
      if (push && !pop)      count <= CNT_W'(count + CNT_W'(1));
      else if (pop && !push) count <= CNT_W'(count - CNT_W'(1));
    end
  end

endmodule

// File: rtl/vram_write_buffer.sv
// Buffers CPU/loader writes to screen memory and commits them to the VRAM write port
// only outside the scan-out line-fetch window, merging repeated writes to the same word.
module vram_write_buffer
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned FETCH_START = H_ACTIVE,
  parameter int unsigned FETCH_STOP  = FETCH_END
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [VRAM_ADDR_W-1:0]  wr_addr,
  input  logic [VRAM_DATA_W-1:0]  wr_data,
  input  logic [9:0]              h_line,
  input  logic                    vram_loaded,
  output logic                    vram_we,
  output logic [VRAM_ADDR_W-1:0]  vram_waddr,
  output logic [VRAM_DATA_W-1:0]  vram_wdata,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                   accept;
  logic                   blocked;
  logic                   pop;
  logic                   push;
  logic                   coalesce;
  logic                   tag_valid;
  logic [VRAM_ADDR_W-1:0] tail_addr;
  vram_wr_t               head;
  vram_wr_t               din;

  assign wr_ready = !rst && (count != CNT_W'(DEPTH));
  assign accept   = wr_valid && wr_ready;

  // Guard cycle on each side of the fetch window.
  assign blocked  = (h_line >= 10'(FETCH_START - 1)) && (h_line <= 10'(FETCH_STOP));
  assign pop      = (count != '0) && vram_loaded && !blocked;

  // Merge only into a newest entry that is not leaving the FIFO on this edge.
  assign coalesce = accept && (count != '0) && tag_valid && (wr_addr == tail_addr)
                    && !(pop && (count == CNT_W'(1)));
  assign push     = accept && !coalesce;

  assign din.addr = wr_addr;
  assign din.data = wr_data;

  vram_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .ovw       (coalesce),
    .din       (din),
    .ovw_data  (wr_data),
    .head      (head),
    .tail_addr (tail_addr),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst) tag_valid <= 1'b0;
    else if (push) tag_valid <= 1'b1;
  end

  // Commit register: strobe for one cycle per pop, address/data hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      vram_we    <= 1'b0;
      vram_waddr <= '0;
      vram_wdata <= '0;
    end else begin
      vram_we <= pop;
      if (pop) begin
        vram_waddr <= head.addr;
        vram_wdata <= head.data;
      end
    end
  end

endmodule
